// File: rtl/ooo_tag_pool_if.sv
// ooo_tag_pool_if: free-tag FIFO, release and status signals between pool and its users
interface ooo_tag_pool_if #(parameter int TAG_NUM = 64);
    localparam int W = $clog2(TAG_NUM);
    logic         tag_fifo_empty;
    logic [W-1:0] tag_fifo_dout;
    logic         tag_fifo_rd_en;
    logic         tag_release_valid;
    logic [W-1:0] tag_release_tag;
    logic         tag_release_ready;
    logic [W:0]   free_count;
    logic         init_done;
    logic         err_underflow;
    logic         err_double_release;
    logic [W-1:0] err_tag;
    modport master (
        input  tag_fifo_empty, tag_fifo_dout, tag_release_ready, free_count, init_done,
               err_underflow, err_double_release, err_tag,
        output tag_fifo_rd_en, tag_release_valid, tag_release_tag
    );
    modport slave (
        output tag_fifo_empty, tag_fifo_dout, tag_release_ready, free_count, init_done,
               err_underflow, err_double_release, err_tag,
        input  tag_fifo_rd_en, tag_release_valid, tag_release_tag
    );
endinterface

// File: rtl/ooo_tag_pool.sv
// ooo_tag_pool: self-initialising FIFO of free tags with double-release guard
module ooo_tag_pool #(
    parameter int TAG_NUM = 64
) (
    input logic           clk,
    input logic           rst,
    ooo_tag_pool_if.slave bus
);
    localparam int W = $clog2(TAG_NUM);

    typedef enum logic {INIT, RUN} state_t;

    state_t           state_q, state_d;
    logic [W-1:0]     init_idx_q, init_idx_d;
    logic [W-1:0]     rd_ptr_q, rd_ptr_d;
    logic [W-1:0]     wr_ptr_q, wr_ptr_d;
    logic [W:0]       count_q, count_d;
    logic [TAG_NUM-1:0] in_use_q, in_use_d;
    logic [W-1:0]     mem_q [TAG_NUM];
    logic [W-1:0]     mem_d [TAG_NUM];
    logic             err_under_q, err_under_d;
    logic             err_dbl_q, err_dbl_d;
    logic [W-1:0]     err_tag_q, err_tag_d;
    logic             run, pop, under, rel_ok, dbl;

    assign run    = state_q == RUN;
    assign pop    = run && bus.tag_fifo_rd_en && count_q != '0;
    assign under  = run && bus.tag_fifo_rd_en && count_q == '0;
    assign rel_ok = run && bus.tag_release_valid && in_use_q[bus.tag_release_tag];
    assign dbl    = run && bus.tag_release_valid && !in_use_q[bus.tag_release_tag];

    assign bus.tag_fifo_empty     = !run || count_q == '0;
    assign bus.tag_fifo_dout      = run ? mem_q[rd_ptr_q] : '0;
    assign bus.tag_release_ready  = run;
    assign bus.init_done          = run;
    assign bus.free_count         = count_q;
    assign bus.err_underflow      = err_under_q;
    assign bus.err_double_release = err_dbl_q;
    assign bus.err_tag            = err_tag_q;

    // next state: init sweep, pops from rd_ptr, accepted releases appended at wr_ptr
    always_comb begin
        state_d    = state_q;
        init_idx_d = init_idx_q;
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        in_use_d   = in_use_q;
        mem_d      = mem_q;
        err_under_d = err_under_q | under;
        err_dbl_d  = err_dbl_q | dbl;
        err_tag_d  = (dbl && !err_dbl_q) ? bus.tag_release_tag : err_tag_q;
        count_d    = count_q + (W+1)'(rel_ok) - (W+1)'(pop);
        if (!run) begin
            mem_d[init_idx_q] = init_idx_q;
            init_idx_d        = init_idx_q + 1'b1;
            if (init_idx_q == W'(TAG_NUM - 1)) begin
                count_d  = (W+1)'(TAG_NUM);
                wr_ptr_d = '0;
                state_d  = RUN;
            end
        end
        if (pop) begin
            rd_ptr_d                 = rd_ptr_q + 1'b1;
            in_use_d[mem_q[rd_ptr_q]] = 1'b1;
        end
        // a releasable tag is in use, so it can never be the tag popped this cycle
        if (rel_ok) begin
            mem_d[wr_ptr_q]               = bus.tag_release_tag;
            wr_ptr_d                      = wr_ptr_q + 1'b1;
            in_use_d[bus.tag_release_tag] = 1'b0;
        end
    end

    // state registers; tag storage needs no reset since INIT rewrites it
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= INIT;
            init_idx_q  <= '0;
            rd_ptr_q    <= '0;
            wr_ptr_q    <= '0;
            count_q     <= '0;
            in_use_q    <= '0;
            err_under_q <= 1'b0;
            err_dbl_q   <= 1'b0;
            err_tag_q   <= '0;
        end else begin
            state_q     <= state_d;
            init_idx_q  <= init_idx_d;
            rd_ptr_q    <= rd_ptr_d;
            wr_ptr_q    <= wr_ptr_d;
            count_q     <= count_d;
            in_use_q    <= in_use_d;
            err_under_q <= err_under_d;
            err_dbl_q   <= err_dbl_d;
            err_tag_q   <= err_tag_d;
        end
        mem_q <= mem_d;
    end
endmodule

// File: tb/tb_ooo_tag_pool.sv
// tb_ooo_tag_pool: random and directed stimulus checked against a queue-based free-tag model
module tb_ooo_tag_pool;
    localparam int N = 64;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    ooo_tag_pool_if #(.TAG_NUM(N)) bus ();
    ooo_tag_pool #(.TAG_NUM(N)) dut (.clk(clk), .rst(rst), .bus(bus));

    int n_vec = 0;
    int n_bad = 0;

    bit run_m;
    int init_m;
    int free_q[$];
    bit in_use_m [N];
    bit eu_m, ed_m;
    int etag_m;

    // compare one observed value against the model's expectation
    task automatic chk(input string tag, input int got, input int exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_all();
        chk("empty", int'(bus.tag_fifo_empty), int'(!run_m || free_q.size() == 0));
        chk("free_count", int'(bus.free_count), run_m ? free_q.size() : 0);
        chk("init_done", int'(bus.init_done), int'(run_m));
        chk("ready", int'(bus.tag_release_ready), int'(run_m));
        chk("err_underflow", int'(bus.err_underflow), int'(eu_m));
        chk("err_double", int'(bus.err_double_release), int'(ed_m));
        chk("err_tag", int'(bus.err_tag), etag_m);
        if (!run_m) chk("dout_init", int'(bus.tag_fifo_dout), 0);
        else if (free_q.size() != 0) chk("dout", int'(bus.tag_fifo_dout), free_q[0]);
    endtask

    // behavioural effect of one clock edge given the inputs applied before it
    task automatic model(input bit r, input bit p, input bit v, input int t);
        bit pre [N];
        int popped;
        if (r) begin
            run_m = 0; init_m = 0; free_q.delete(); eu_m = 0; ed_m = 0; etag_m = 0;
            foreach (in_use_m[i]) in_use_m[i] = 0;
            return;
        end
        if (!run_m) begin
            if (init_m == N - 1) begin
                run_m = 1;
                for (int i = 0; i < N; i++) free_q.push_back(i);
            end
            init_m++;
            return;
        end
        pre = in_use_m;
        popped = -1;
        if (p) begin
            if (free_q.size() > 0) popped = free_q.pop_front();
            else eu_m = 1;
        end
        if (v) begin
            if (pre[t]) begin
                free_q.push_back(t);
                in_use_m[t] = 0;
            end else begin
                if (!ed_m) etag_m = t;
                ed_m = 1;
            end
        end
        if (popped >= 0) in_use_m[popped] = 1;
    endtask

    task automatic step(input bit r, input bit p, input bit v, input int t);
        rst = r;
        bus.tag_fifo_rd_en = p;
        bus.tag_release_valid = v;
        bus.tag_release_tag = 6'(t);
        @(posedge clk);
        model(r, p, v, t);
        @(negedge clk);
        check_all();
    endtask

    function automatic int pick_tag();
        int c;
        if ($urandom_range(9) < 8) begin
            c = $urandom_range(N - 1);
            for (int k = 0; k < N; k++) if (in_use_m[(c + k) % N]) return (c + k) % N;
        end
        return $urandom_range(N - 1);
    endfunction

    task automatic random_run(input int cycles, input int pop_pct, input int rel_pct);
        for (int i = 0; i < cycles; i++)
            step(0, $urandom_range(99) < pop_pct, $urandom_range(99) < rel_pct, pick_tag());
    endtask

    initial begin
        bus.tag_fifo_rd_en = 0;
        bus.tag_release_valid = 0;
        bus.tag_release_tag = 0;
        @(negedge clk);
        step(1, 0, 0, 0);
        step(1, 1, 1, 3);
        for (int i = 0; i < N; i++) step(0, $urandom_range(1), 0, 0);
        for (int i = 0; i < 3; i++) step(0, 1, 0, 0);
        step(0, 0, 1, 1);
        while (free_q.size() > 0) step(0, 1, 0, 0);
        step(0, 1, 0, 0);
        step(0, 1, 1, 5);
        step(0, 0, 1, 5);
        for (int t = 10; t < 19; t++) step(0, 0, 1, t);
        step(0, 1, 1, 7);
        step(0, 0, 1, 9);
        step(0, 0, 1, 9);
        step(0, 0, 1, 12);
        step(0, 1, 1, int'(bus.tag_fifo_dout));
        random_run(300, 50, 50);
        random_run(200, 80, 20);
        random_run(200, 20, 80);
        step(1, 1, 1, pick_tag());
        step(0, 0, 0, 0);
        for (int i = 0; i < N; i++) step(0, 1, 1, $urandom_range(N - 1));
        random_run(400, 55, 45);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule

// File: doc/ooo_tag_pool.md
Name: ooo_tag_pool

Overview:
Free-tag pool that feeds the OoO station ingress thread's tag FIFO interface (tag_fifo_empty / tag_fifo_dout / tag_fifo_rd_en). After reset it self-initialises with every tag 0..TAG_NUM-1. It hands out tags in FIFO order and accepts tags recycled by the egress/response thread once a resource response retires. An in-use bitmap guards against double release; underflow and double-release errors are flagged sticky.

Parameters:
TAG_NUM, 64, number of request tags; must be a power of 2, at least 2.
TAG_NUM_LOG, log2b(TAG_NUM - 1), tag index width.

Ports:
clk  input  1  single clock
rst  input  1  synchronous, active-high reset
tag_fifo_empty  output  1  no free tag available (also held 1 during init)
tag_fifo_dout  output  TAG_NUM_LOG  head free tag; first-word-fall-through, valid when !tag_fifo_empty
tag_fifo_rd_en  input  1  pop the head tag (allocation)
tag_release_valid  input  1  recycled-tag request
tag_release_tag  input  TAG_NUM_LOG  tag being returned
tag_release_ready  output  1  pool accepts a release
free_count  output  TAG_NUM_LOG+1  number of free tags
init_done  output  1  pool initialised and operational
err_underflow  output  1  sticky: pop attempted while empty in RUN
err_double_release  output  1  sticky: released tag was not in use
err_tag  output  TAG_NUM_LOG  tag of the first double release

Behaviour:
- Storage: TAG_NUM x TAG_NUM_LOG register array; rd_ptr and wr_ptr are TAG_NUM_LOG wide and wrap naturally. in_use is a TAG_NUM-bit bitmap. count is TAG_NUM_LOG+1 wide.
- FSM states: INIT, RUN.
- Reset (rst=1 at a clk edge, including mid-operation): state=INIT, init_idx=0, rd_ptr=0, wr_ptr=0, count=0, in_use=0, all error flags and err_tag=0. Any pending release or pop is discarded.
- Output reset values: tag_fifo_empty=1, tag_fifo_dout=0, tag_release_ready=0, free_count=0, init_done=0, err_*=0.
- INIT:
  - Each cycle: mem[init_idx] <= init_idx; init_idx++.
  - When init_idx == TAG_NUM-1 is written: count <= TAG_NUM, wr_ptr <= 0, state -> RUN.
  - INIT lasts exactly TAG_NUM cycles after reset deassertion.
  - tag_fifo_empty=1 and tag_release_ready=0 throughout. tag_fifo_rd_en is ignored and does not raise an error.
- RUN:
  - tag_fifo_empty = (count==0); tag_fifo_dout = mem[rd_ptr] (combinational); tag_release_ready=1; init_done=1; free_count=count.
- Pop (tag_fifo_rd_en && count!=0): rd_ptr++, in_use[mem[rd_ptr]] <= 1.
- Pop when count==0: no state change; err_underflow <= 1.
- Release (tag_release_valid, always accepted in RUN):
  - If in_use[tag]==1: mem[wr_ptr] <= tag, wr_ptr++, in_use[tag] <= 0.
  - If in_use[tag]==0: the release is dropped. err_double_release <= 1. err_tag captures the tag only on the first error (while the flag is 0).
  - The in_use check uses the pre-edge bitmap. Releasing the tag being popped in the same cycle is therefore a double release.
- Simultaneous valid pop and valid release: both occur and count is unchanged.
  - If count==0, the pop is an underflow even when a release occurs in the same cycle. There is no bypass: a released tag becomes visible at tag_fifo_dout the next cycle.
- count update: +1 on a valid release, -1 on a valid pop, net 0 for both. count never exceeds TAG_NUM, guaranteed by the in_use check.
- Latency:
  - A pop is reflected in dout/empty/free_count on the next cycle.
  - A released tag is poppable 1 cycle after acceptance when the pool was empty; otherwise it queues behind the existing free tags in FIFO order.
- Error flags clear only on rst.

Test Plan:
- Reset, then idle 64 cycles -> init_done rises exactly on cycle 64 after reset deassertion; free_count=64, tag_fifo_empty=0, tag_fifo_dout=0; rd_en pulses during INIT produce no pops and err_underflow=0.
- After init, pop 3 times back-to-back -> dout sequence 0,1,2, then dout=3, free_count=61; release tag 1 -> free_count=62, and tag 1 comes out after tags 3..63 (65th pop overall returns 1).
- Pop all 64 tags -> tag_fifo_empty=1, free_count=0; extra rd_en -> err_underflow=1 (sticky), free_count stays 0; release tag 5 -> empty=0 next cycle, dout=5.
- With free_count=10, assert pop and release of an in-use tag 7 in the same cycle -> free_count stays 10, tag 7 written at wr_ptr, in_use[7]=0.
- Release tag 9 twice (second while not in use), then tag 12 not in use -> err_double_release=1, err_tag=9 (not 12), free_count increments only once.
- Assert rst mid-run with free_count=20 and errors set -> next cycle all outputs at reset values; re-init completes after 64 cycles with free_count=64 and errors cleared.
